mem_responder: RTL and testbench
================================

# mem_responder

Unified instruction/data memory that services the multicycle control path's memory requests: instruction fetch, load, and store. It sits between the datapath address/data muxes (I-or-D select, write-data register) and the storage array. It accepts one request at a time over a valid/ready handshake, returns the result after a fixed, parameterised latency, and flags misaligned or out-of-range accesses. It lets the control FSM stall in its fetch, load and store states until memory answers.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, word width; fixed at 32 (4 bytes per word)
- DEPTH_WORDS, 256, number of words; power of two, ≥ 2
- LATENCY, 2, cycles from request cycle to response cycle; range 1..15
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_write  in  1  1 = store, 0 = load/fetch
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data
- req_wstrb  in  4  byte-lane enables; present only with MEM_BYTE_ENABLE_EN
- req_ready  out  1  request can be accepted this cycle
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  access was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, the request is accepted at the clock edge and the FSM moves to WAIT (LATENCY>1) or RESP (LATENCY=1). The latency counter loads LATENCY-1.
- WAIT: the counter decrements once per cycle. At 1 the FSM moves to RESP. req_ready=0. Input requests are ignored and not buffered.
- RESP: resp_valid=1 and outputs are held stable. Once resp_valid=1 and resp_ready=1, the FSM returns to IDLE.
- Error: addr[1:0]≠0 or word index ≥ DEPTH_WORDS. resp_err=1 and resp_rdata=0. A store with an error does not modify the array.
- Word index is req_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits beyond the array cause an error; they never wrap.
- Loads read the array at the acceptance edge into the response register.
- Stores write the array at the acceptance edge. resp_rdata=0 for stores.
- A load that follows a store sees the stored data, because only one request is outstanding at a time.
- Reset values:
  - FSM=IDLE, counter=0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Array contents are not reset.
- Reset mid-operation (WAIT/RESP): the response is dropped and the FSM returns to IDLE. A store already accepted remains committed.

## Timing
- Request presented and accepted in cycle 0. resp_valid=1 first in cycle LATENCY.
- Response backpressure: resp_valid stays high through any number of cycles with resp_ready=0. The data stays constant.
- Handshake completes in cycle N (resp_valid=1, resp_ready=1). req_ready=1 from cycle N+1. There is no same-cycle bypass.
- Maximum throughput is one request per LATENCY+1 cycles.
- req_ready depends only on FSM state, never combinationally on any input.

## Configuration
- MEM_BYTE_ENABLE_EN defined:
  - req_wstrb port exists.
  - A store writes only the lanes where wstrb[i]=1 (lane i = bits 8i+7:8i).
  - A store with wstrb=0 is a legal no-op that still returns a response.
- Undefined:
  - No req_wstrb port.
  - Every store writes the full 32-bit word.
- Alignment checking is identical in both builds.

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - the BYTES_PER_WORD=4 constant
  - the counter width constant LAT_CNT_W=4
- Sub-module mem_array: synchronous storage array.
  - Interface: one read/write port, word index, write enable, and 4-bit lane mask (tied to 4'hF when the macro is off).
  - Holds no handshake logic.
- mem_responder holds the FSM, counter, error check, and response registers.

## Test plan
- Reset then idle: rst pulse mid-cycle → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 immediately, without waiting for a clock edge.
- Store/load round trip (LATENCY=2):
  - Store 0xDEADBEEF to 0x10, resp_valid in cycle 2 with rdata=0, err=0.
  - Then load 0x10 → resp_rdata=0xDEADBEEF in cycle 2 of that request.
- Backpressure: load held with resp_ready=0 for 5 cycles → resp_valid and rdata stable; req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- Errors:
  - Load 0x12 → resp_err=1, rdata=0.
  - Store to 0x400 (DEPTH_WORDS=256) → resp_err=1.
  - A later load of 0x000 shows the array unchanged.
- Byte enables (MEM_BYTE_ENABLE_EN): word 0x11223344 at 0x20; store 0xAABBCCDD with wstrb=4'b0101 → load returns 0x11BB33DD.
- Reset in WAIT: assert rst one cycle after accepting a store → no resp_valid afterward; a subsequent load shows the stored data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LAT_CNT_W      = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port word array: byte-lane masked writes and registered reads, no reset on contents.
module mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_WIDTH  = 32,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [3:0]            lane_mask,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (lane_mask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Unified I/D memory behind a valid/ready request and a fixed-latency held response.
// Optional per-byte store lanes are enabled with `define MEM_BYTE_ENABLE_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
`ifdef MEM_BYTE_ENABLE_EN
  input  logic [BYTES_PER_WORD-1:0] req_wstrb,
`endif
  output logic                      req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t                 state;
  logic [LAT_CNT_W-1:0]   cnt;
  logic                   rdata_ok;
  logic                   accept;
  logic                   addr_err;
  logic [IDX_W-1:0]       idx;
  logic [3:0]             lane_mask;
  logic [DATA_WIDTH-1:0]  arr_rdata;

  assign accept = req_ready && req_valid;
  assign idx    = req_addr[IDX_W+1:2];
  // Any set bit above the word index is out of range; the index never wraps.
  assign addr_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);

`ifdef MEM_BYTE_ENABLE_EN
  assign lane_mask = req_wstrb;
`else
  assign lane_mask = 4'hF;
`endif

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .en       (accept && !addr_err),
    .we       (req_write),
    .idx      (idx),
    .lane_mask(lane_mask),
    .wdata    (req_wdata),
    .rdata    (arr_rdata)
  );

  // The array read register holds its value until the next accepted load,
  // so gating it with a registered flag keeps the response stable.
  assign resp_rdata = rdata_ok ? arr_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata_ok   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            resp_err  <= addr_err;
            rdata_ok  <= !req_write && !addr_err;
            cnt       <= LAT_CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == LAT_CNT_W'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata_ok   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, round trips, backpressure, errors, lanes, reset in WAIT.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
`ifdef MEM_BYTE_ENABLE_EN
  logic [3:0]  req_wstrb = 4'hF;
`endif
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_WORDS(256),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef MEM_BYTE_ENABLE_EN
    .req_wstrb (req_wstrb),
`endif
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with resp_ready held high; checks every cycle's handshake signals.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_d, input logic exp_e, input string tag);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    check({tag, "_rdy_c0"}, req_ready, 1);
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      check({tag, "_vld_early"}, resp_valid, 0);
      check({tag, "_rdy_busy"}, req_ready, 0);
      step();
    end
    check({tag, "_vld"}, resp_valid, 1);
    check({tag, "_rdata"}, resp_rdata, exp_d);
    check({tag, "_err"}, resp_err, exp_e);
    step();
    check({tag, "_rdy_after"}, req_ready, 1);
    check({tag, "_vld_after"}, resp_valid, 0);
  endtask

  initial begin
    // Asynchronous reset, asserted between clock edges
    #3 rst = 1'b1;
    #1;
    check("rst_rdy", req_ready, 1);
    check("rst_vld", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Store/load round trip
    txn(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st10");
    txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld10");

    // Errors: known word 0, misaligned load, out-of-range store that must not alias word 0
    txn(1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0, "st00");
    txn(1'b0, 32'h12, 32'h0, 32'h0, 1'b1, "ld12");
    txn(1'b1, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1, "st400");
    txn(1'b1, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1, "st13");
    txn(1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, "ld00");

    // Backpressure: hold the response for 5 cycles
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h10;
    step();
    req_valid = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_vld", resp_valid, 1);
      check("bp_rdata", resp_rdata, 32'hDEADBEEF);
      check("bp_rdy", req_ready, 0);
      step();
    end
    resp_ready = 1'b1;
    check("bp_vld_hs", resp_valid, 1);
    check("bp_rdy_hs", req_ready, 0);
    step();
    check("bp_rdy_after", req_ready, 1);
    check("bp_vld_after", resp_valid, 0);

`ifdef MEM_BYTE_ENABLE_EN
    req_wstrb = 4'hF;
    txn(1'b1, 32'h20, 32'h11223344, 32'h0, 1'b0, "be_full");
    req_wstrb = 4'b0101;
    txn(1'b1, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, "be_part");
    req_wstrb = 4'b0000;
    txn(1'b1, 32'h20, 32'h55555555, 32'h0, 1'b0, "be_none");
    req_wstrb = 4'hF;
    txn(1'b0, 32'h20, 32'h0, 32'h11BB33DD, 1'b0, "be_ld");
`endif

    // Reset one cycle after accepting a store: response dropped, data committed
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'hCAFEF00D;
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
    rst = 1'b1;
    #1;
    check("rw_rdy", req_ready, 1);
    check("rw_vld", resp_valid, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("rw_no_vld", resp_valid, 0);
      step();
    end
    txn(1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, "rw_ld30");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
